// File: rtl/iddmm_pkg.sv
// ============================================================================
//  iddmm_pkg : constants and helpers shared across the IDDMM datapath
//  Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package iddmm_pkg;

   localparam int WIDTH_129 = 129;
   localparam int SUB_CHUNK = 64;

   function automatic int ceil_div(input int n, input int d);
      return (n + d - 1) / d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/simple_p3sub129_if.sv
// ============================================================================
//  simple_p3sub129_if : valid/ready operand and result bus of the subtractor
//  Rev 1.0            : initial release
// ============================================================================
`default_nettype none

interface simple_p3sub129_if
   import iddmm_pkg::*;
#(
   parameter int WIDTH = WIDTH_129
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] ain;
   logic [WIDTH-1:0] bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output in_valid, ain, bin, out_ready,
      input  in_ready, out_valid, diff, borrow
   );

   modport slave (
      input  in_valid, ain, bin, out_ready,
      output in_ready, out_valid, diff, borrow
   );

endinterface

`default_nettype wire

// File: rtl/sub_slice_stage.sv
// ============================================================================
//  sub_slice_stage : one registered slice of the borrow-chain subtractor
//  Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module sub_slice_stage #(
   parameter int SW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_en,
   input  logic [SW-1:0] i_a,
   input  logic [SW-1:0] i_b,
   input  logic          i_borrow,
   input  logic          i_valid,
   output logic [SW-1:0] o_d,
   output logic          o_borrow,
   output logic          o_valid
);

   // One extra bit on top captures the borrow out of this slice.
   logic [SW:0] w_res;

   assign w_res = {1'b0, i_a} - {1'b0, i_b} - {{SW{1'b0}}, i_borrow};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_d      <= '0;
         o_borrow <= 1'b0;
         o_valid  <= 1'b0;
      end else if (i_en) begin
         o_d      <= w_res[SW-1:0];
         o_borrow <= w_res[SW];
         o_valid  <= i_valid;
      end
   end

endmodule

`default_nettype wire

// File: rtl/simple_p3sub129.sv
// ============================================================================
//  simple_p3sub129 : pipelined WIDTH-bit subtractor, one CHUNK slice per stage
//  Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module simple_p3sub129
   import iddmm_pkg::*;
#(
   parameter int WIDTH = WIDTH_129,
   parameter int CHUNK = SUB_CHUNK
) (
   input  logic               clk,
   input  logic               rst,
   simple_p3sub129_if.slave   bus
);

   localparam int NSTG = ceil_div(WIDTH, CHUNK);

   logic w_adv;

   // Whole-pipe stall: every stage moves together or not at all.
   assign w_adv       = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = w_adv;

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int LO = k * CHUNK;
      localparam int HI = (k == NSTG - 1) ? WIDTH - 1 : LO + CHUNK - 1;
      localparam int SW = HI - LO + 1;

      // Operand bits from this slice upward, as seen by this stage.
      logic [WIDTH-LO-1:0] w_a_hi;
      logic [WIDTH-LO-1:0] w_b_hi;
      logic                w_bi;
      logic                w_vi;
      logic [SW-1:0]       w_d;
      logic                w_bo;
      logic                w_vo;
      logic [HI:0]         w_dacc;

      if (k == 0) begin : g_head
         assign w_a_hi = bus.ain;
         assign w_b_hi = bus.bin;
         assign w_bi   = 1'b0;
         assign w_vi   = bus.in_valid;
         assign w_dacc = w_d;
      end else begin : g_body
         logic [LO-1:0] r_dlo;

         assign w_a_hi = g_stg[k-1].g_up.r_a_up;
         assign w_b_hi = g_stg[k-1].g_up.r_b_up;
         assign w_bi   = g_stg[k-1].w_bo;
         assign w_vi   = g_stg[k-1].w_vo;
         assign w_dacc = {w_d, r_dlo};

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_dlo <= '0;
            end else if (w_adv) begin
               r_dlo <= g_stg[k-1].w_dacc;
            end
         end
      end

      if (k < NSTG - 1) begin : g_up
         logic [WIDTH-HI-2:0] r_a_up;
         logic [WIDTH-HI-2:0] r_b_up;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_a_up <= '0;
               r_b_up <= '0;
            end else if (w_adv) begin
               r_a_up <= w_a_hi[WIDTH-LO-1:SW];
               r_b_up <= w_b_hi[WIDTH-LO-1:SW];
            end
         end
      end

      sub_slice_stage #(
         .SW (SW)
      ) u_slice (
         .clk      (clk),
         .rst      (rst),
         .i_en     (w_adv),
         .i_a      (w_a_hi[SW-1:0]),
         .i_b      (w_b_hi[SW-1:0]),
         .i_borrow (w_bi),
         .i_valid  (w_vi),
         .o_d      (w_d),
         .o_borrow (w_bo),
         .o_valid  (w_vo)
      );
   end

   assign bus.diff      = g_stg[NSTG-1].w_dacc;
   assign bus.borrow    = g_stg[NSTG-1].w_bo;
   assign bus.out_valid = g_stg[NSTG-1].w_vo;

endmodule

`default_nettype wire

// File: doc/simple_p3sub129.md
Name: simple_p3sub129

Overview:
- Pipelined 129-bit subtractor, the inverse of the team's pipelined 129-bit adder: computes diff = ain - bin (mod 2^129) plus a borrow-out flag.
- Used in the IDDMM datapath for the final conditional subtraction (result - M) and for the comparison that selects it.
- Borrow-chain is split into CHUNK-bit slices, one slice per pipeline stage.
- Valid/ready flow control on both sides, with a whole-pipe stall on backpressure.

Parameters:
- WIDTH, 129, operand width in bits.
- CHUNK, 64, bits resolved per pipeline stage.
- NSTG, ceil(WIDTH/CHUNK) = 3, number of stages. Derived; must not be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ain/bin are valid this cycle.
- in_ready  output  1  block accepts the operands this cycle.
- ain  input  WIDTH  minuend, unsigned.
- bin  input  WIDTH  subtrahend, unsigned.
- out_valid  output  1  diff/borrow are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- diff  output  WIDTH  (ain - bin) mod 2^WIDTH.
- borrow  output  1  1 iff ain < bin (unsigned).

Behaviour:
- Reset: rst asserted clears all stage valid bits, all data/borrow registers, diff, borrow and out_valid to 0, at any time, including mid-operation. In-flight operands are dropped. in_ready = 1 during and after reset.
- Advance signal: adv = !out_valid || out_ready.
  - All stages load simultaneously when adv = 1.
  - When adv = 0 every stage holds its contents.
  - A stall is global; bubbles are not compressed.
- in_ready = adv, combinational. A transfer occurs when in_valid && in_ready.
- Stage 1 (on adv):
  - registers {b1, d1} = ain[CHUNK-1:0] - bin[CHUNK-1:0] (CHUNK+1-bit result; b1 is the borrow).
  - registers the remaining upper bits of ain and bin.
  - v1 <= in_valid.
- Stage 2: {b2, d2} = ain[2*CHUNK-1:CHUNK] - bin[2*CHUNK-1:CHUNK] - b1. Carries d1 forward and the remaining upper bits. v2 <= v1.
- Stage 3: {b3, d3} = ain[WIDTH-1:2*CHUNK] - bin[WIDTH-1:2*CHUNK] - b2 (1-bit slice at the default width). Result diff = {d3, d2, d1}, borrow = b3, out_valid <= v2.
- Latency: a result is presented exactly 3 clk edges after acceptance when never stalled.
- Throughput: 1 operation/cycle at full rate.
- Order: strictly in order; no reordering or drop except on reset.
- Outputs are registered. diff and borrow hold stable while out_valid && !out_ready.
- A bubble (in_valid = 0 on an advancing cycle) propagates as out_valid = 0 three edges later. diff/borrow content is don't-care when out_valid = 0, but is deterministic: it is the registered data.
- Simultaneous out_ready = 1 with a new input: the result leaves and the input enters on the same edge.
- Arithmetic:
  - pure unsigned, modulo 2^WIDTH.
  - ain == bin gives diff = 0, borrow = 0.
  - the borrow chain must ripple correctly across every slice boundary.
- Generic WIDTH/CHUNK: the last slice width is WIDTH - (NSTG-1)*CHUNK and must be ≥ 1.

Decomposition:
- Shared package iddmm_pkg holds:
  - constants WIDTH_129 = 129 and SUB_CHUNK = 64.
  - a localparam function for the ceil-divide that computes NSTG.
- One natural sub-module: sub_slice_stage.
  - Parameterised slice width.
  - Inputs: a-slice, b-slice, borrow-in, enable, valid-in.
  - Registered outputs: d-slice, borrow-out, valid-out.
  - Async reset.
  - Instantiated NSTG times in a generate loop. The pass-through operand/result shift registers stay in the top level.

Test Plan:
1. Borrow ripple through every slice: ain = 2^128, bin = 1, out_ready = 1 → after 3 edges diff = 2^128 - 1 (bits 127:0 all ones, bit128 = 0), borrow = 0, out_valid = 1.
2. Negative result: ain = 0, bin = 1 → diff = 2^129 - 1 (all 129 bits 1), borrow = 1. Also ain = bin = 0x1_2345…(random) → diff = 0, borrow = 0.
3. Back-to-back throughput: drive 100 random pairs on consecutive cycles with out_ready = 1 → 100 results on consecutive cycles starting at cycle 3, in order, each matching the model (a - b) mod 2^129 and borrow = (a < b).
4. Backpressure: stream 5 operations, hold out_ready = 0 for 4 cycles after the first result appears → in_ready = 0 during the hold, diff/borrow stable, no loss or duplication. All 5 results are delivered in order once out_ready = 1.
5. Bubbles: alternate in_valid 1/0 with out_ready = 1 → out_valid pattern 1/0 delayed by 3 cycles, and the data match.
6. Reset mid-flight: accept 2 operations, assert rst asynchronously between edges → out_valid drops to 0 immediately and all outputs read 0. After deassertion the next operation (ain = 5, bin = 3) gives diff = 2, borrow = 0 after 3 edges, with no stale result appearing.
